// File: rtl/spi_rx_sequencer_pkg.sv
// Shared types and defaults for the SPI receive sequencer and its word assembler.
package spi_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CAL_START = 3'd1,
        ST_CAL_WAIT  = 3'd2,
        ST_RUN       = 3'd3,
        ST_DRAIN     = 3'd4,
        ST_ERROR     = 3'd5
    } rx_seq_state_t;

    localparam int unsigned DEF_FRAME_BITS = 8;

    function automatic logic cal_en_state(input rx_seq_state_t s);
        return (s == ST_CAL_START) || (s == ST_CAL_WAIT) || (s == ST_RUN);
    endfunction

endpackage

// File: rtl/spi_rx_sequencer_if.sv
// Control, bit-source and FIFO-write signals of the SPI receive sequencer.
interface spi_rx_sequencer_if #(
    parameter int unsigned FRAME_BITS = spi_rx_pkg::DEF_FRAME_BITS
);
    logic                  start;
    logic                  stop;
    logic                  clear_flags;
    logic                  cal_done;
    logic                  sample_valid;
    logic                  sample_bit;
    logic                  fifo_full;
    logic                  phase_cal_en;
    logic                  cal_restart;
    logic                  fifo_wr_en;
    logic [FRAME_BITS-1:0] fifo_din;
    logic                  busy;
    logic                  cal_error;
    logic                  overflow;
    logic [2:0]            state_o;

    modport slave (
        input  start, stop, clear_flags, cal_done, sample_valid, sample_bit, fifo_full,
        output phase_cal_en, cal_restart, fifo_wr_en, fifo_din, busy, cal_error, overflow, state_o
    );

    modport master (
        output start, stop, clear_flags, cal_done, sample_valid, sample_bit, fifo_full,
        input  phase_cal_en, cal_restart, fifo_wr_en, fifo_din, busy, cal_error, overflow, state_o
    );
endinterface

// File: rtl/spi_rx_sequencer_word_assembler.sv
// MSB-first serial-to-parallel packer; o_done/o_word describe the word completed by the current bit.
module rx_word_assembler
    import spi_rx_pkg::*;
#(
    parameter int unsigned FRAME_BITS = DEF_FRAME_BITS
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_clr,
    input  logic                  i_valid,
    input  logic                  i_bit,
    output logic                  o_done,
    output logic [FRAME_BITS-1:0] o_word
);
    localparam int unsigned CW = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
    localparam logic [CW-1:0] LAST = CW'(FRAME_BITS - 1);

    logic [FRAME_BITS-1:0] r_shift;
    logic [CW-1:0]         r_bit_cnt;
    logic [FRAME_BITS-1:0] w_shift_next;

    assign w_shift_next = (r_shift << 1) | FRAME_BITS'(i_bit);
    assign o_done       = i_valid && (r_bit_cnt == LAST);
    assign o_word       = w_shift_next;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
        end else if (i_clr) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
        end else if (i_valid) begin
            r_shift   <= w_shift_next;
            r_bit_cnt <= (r_bit_cnt == LAST) ? '0 : r_bit_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/spi_rx_sequencer.sv
// SPI receive sequencer: calibration supervision, word packing into the FIFO, periodic recalibration.
module spi_rx_sequencer
    import spi_rx_pkg::*;
#(
    parameter int unsigned CAL_TIMEOUT = 1023,
    parameter int unsigned RECAL_BYTES = 4096,
    parameter int unsigned FRAME_BITS  = DEF_FRAME_BITS
) (
    input logic              CLK_40,
    input logic              reset,
    spi_rx_sequencer_if.slave bus
);
    localparam int unsigned TW = $clog2(CAL_TIMEOUT + 1);
    localparam int unsigned BW = $clog2(RECAL_BYTES + 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(CAL_TIMEOUT - 1);
    localparam logic [BW-1:0] RECAL_CNT = BW'(RECAL_BYTES);

    rx_seq_state_t         r_state;
    rx_seq_state_t         w_next;
    logic [TW-1:0]         r_tmo_cnt;
    logic [BW-1:0]         r_byte_cnt;
    logic                  w_set_cal_err;
    logic                  w_accept;
    logic                  w_asm_clr;
    logic                  w_done;
    logic [FRAME_BITS-1:0] w_word;

    assign w_accept  = (r_state == ST_RUN) && bus.sample_valid;
    assign w_asm_clr = (r_state == ST_CAL_START) || (r_state == ST_DRAIN);

    rx_word_assembler #(.FRAME_BITS(FRAME_BITS)) u_asm (
        .i_clk   (CLK_40),
        .i_rst_n (reset),
        .i_clr   (w_asm_clr),
        .i_valid (w_accept),
        .i_bit   (bus.sample_bit),
        .o_done  (w_done),
        .o_word  (w_word)
    );

    // The CAL_WAIT cycle count is r_tmo_cnt+1, so the last allowed cycle sees CAL_TIMEOUT-1.
    always_comb begin
        w_next        = r_state;
        w_set_cal_err = 1'b0;
        case (r_state)
            ST_IDLE:      if (bus.start) w_next = ST_CAL_START;
            ST_CAL_START: w_next = ST_CAL_WAIT;
            ST_CAL_WAIT: begin
                if (bus.cal_done) begin
                    w_next = ST_RUN;
                end else if (r_tmo_cnt == TMO_LAST) begin
                    w_next        = ST_ERROR;
                    w_set_cal_err = 1'b1;
                end
            end
            ST_RUN: begin
                if (bus.stop)                      w_next = ST_DRAIN;
                else if (r_byte_cnt == RECAL_CNT)  w_next = ST_CAL_START;
            end
            ST_DRAIN:     w_next = ST_IDLE;
            ST_ERROR:     if (bus.start) w_next = ST_CAL_START;
            default:      w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK_40 or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_tmo_cnt  <= '0;
            r_byte_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_CAL_START) begin
                r_tmo_cnt  <= '0;
                r_byte_cnt <= '0;
            end else begin
                if (r_state == ST_CAL_WAIT) r_tmo_cnt <= r_tmo_cnt + 1'b1;
                if (w_done)                 r_byte_cnt <= r_byte_cnt + 1'b1;
            end
        end
    end

    // Status outputs are registered from the next state so they line up with r_state.
    always_ff @(posedge CLK_40 or negedge reset) begin
        if (!reset) begin
            bus.phase_cal_en <= 1'b0;
            bus.cal_restart  <= 1'b0;
            bus.busy         <= 1'b0;
            bus.state_o      <= '0;
            bus.fifo_wr_en   <= 1'b0;
            bus.fifo_din     <= '0;
            bus.cal_error    <= 1'b0;
            bus.overflow     <= 1'b0;
        end else begin
            bus.phase_cal_en <= cal_en_state(w_next);
            bus.cal_restart  <= (w_next == ST_CAL_START);
            bus.busy         <= (w_next != ST_IDLE);
            bus.state_o      <= w_next;
            bus.fifo_wr_en   <= w_done && !bus.fifo_full;
            if (w_done && !bus.fifo_full) bus.fifo_din <= w_word;

            if (w_set_cal_err)        bus.cal_error <= 1'b1;
            else if (bus.clear_flags) bus.cal_error <= 1'b0;

            if (w_done && bus.fifo_full) bus.overflow <= 1'b1;
            else if (bus.clear_flags)    bus.overflow <= 1'b0;
        end
    end
endmodule

// File: tb/tb_spi_rx_sequencer.sv
// Directed + randomized bench for spi_rx_sequencer against a word-level reference model.
module tb_spi_rx_sequencer;
    import spi_rx_pkg::*;

    localparam int unsigned FB    = 8;
    localparam int unsigned TMO   = 60;
    localparam int unsigned RECAL = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [7:0]  exp_din;
    logic        exp_ovf;
    logic        exp_err;
    int unsigned exp_bytes;

    spi_rx_sequencer_if #(.FRAME_BITS(FB)) bus();

    spi_rx_sequencer #(
        .CAL_TIMEOUT (TMO),
        .RECAL_BYTES (RECAL),
        .FRAME_BITS  (FB)
    ) dut (
        .CLK_40 (clk),
        .reset  (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_flags(input string tag);
        chk({tag, ".overflow"},  bus.overflow,  exp_ovf);
        chk({tag, ".cal_error"}, bus.cal_error, exp_err);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".state"},    bus.state_o,      0);
        chk({tag, ".pce"},      bus.phase_cal_en, 0);
        chk({tag, ".restart"},  bus.cal_restart,  0);
        chk({tag, ".wr_en"},    bus.fifo_wr_en,   0);
        chk({tag, ".din"},      bus.fifo_din,     0);
        chk({tag, ".busy"},     bus.busy,         0);
        chk({tag, ".cal_err"},  bus.cal_error,    0);
        chk({tag, ".overflow"}, bus.overflow,     0);
    endtask

    task automatic start_cal(input string tag);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk({tag, ".st_start"}, bus.state_o,      1);
        chk({tag, ".restart"},  bus.cal_restart,  1);
        chk({tag, ".pce"},      bus.phase_cal_en, 1);
        chk({tag, ".busy"},     bus.busy,         1);
        exp_bytes = 0;
    endtask

    // cal_done is given in the n-th CAL_WAIT cycle (n >= 1).
    task automatic wait_cal(input string tag, input int unsigned n);
        tick();
        chk({tag, ".st_wait"},    bus.state_o,      2);
        chk({tag, ".restart_lo"}, bus.cal_restart,  0);
        chk({tag, ".pce_wait"},   bus.phase_cal_en, 1);
        repeat (n - 1) tick();
        chk({tag, ".still_wait"}, bus.state_o, 2);
        bus.cal_done = 1'b1;
        tick();
        bus.cal_done = 1'b0;
        chk({tag, ".st_run"},  bus.state_o,      3);
        chk({tag, ".pce_run"}, bus.phase_cal_en, 1);
        chk_flags({tag, ".run"});
    endtask

    task automatic send_bit(input logic b, input logic full, input logic stp, input logic clr);
        bus.sample_valid = 1'b1;
        bus.sample_bit   = b;
        bus.fifo_full    = full;
        bus.stop         = stp;
        bus.clear_flags  = clr;
        tick();
        bus.sample_valid = 1'b0;
        bus.sample_bit   = 1'b0;
        bus.fifo_full    = 1'b0;
        bus.stop         = 1'b0;
        bus.clear_flags  = 1'b0;
    endtask

    task automatic send_byte(input string tag, input logic [7:0] d, input logic full,
                             input int unsigned gap_max, input logic clr_last, output logic recal);
        int unsigned g;
        int unsigned i;
        recal = 1'b0;
        for (int unsigned k = 0; k < 8; k++) begin
            i = 7 - k;
            g = $urandom_range(gap_max, 0);
            repeat (g) begin
                bus.fifo_full = 1'($urandom_range(1, 0));
                tick();
                bus.fifo_full = 1'b0;
                chk({tag, ".gap_wr"}, bus.fifo_wr_en, 0);
            end
            if (i == 0) begin
                send_bit(d[i], full, 1'b0, clr_last);
            end else begin
                send_bit(d[i], 1'($urandom_range(1, 0)), 1'b0, 1'b0);
                chk({tag, ".bit_wr"}, bus.fifo_wr_en, 0);
            end
        end
        exp_bytes++;
        if (clr_last) exp_err = 1'b0;
        if (full)          exp_ovf = 1'b1;
        else begin
            exp_din = d;
            if (clr_last) exp_ovf = 1'b0;
        end
        chk({tag, ".wr"},  bus.fifo_wr_en, {31'd0, !full});
        chk({tag, ".din"}, bus.fifo_din,   exp_din);
        chk_flags(tag);
        tick();
        chk({tag, ".wr_pulse"}, bus.fifo_wr_en, 0);
        chk({tag, ".din_hold"}, bus.fifo_din,   exp_din);
        if (exp_bytes == RECAL) begin
            chk({tag, ".recal_st"},  bus.state_o,      1);
            chk({tag, ".recal_rst"}, bus.cal_restart,  1);
            chk({tag, ".recal_pce"}, bus.phase_cal_en, 1);
            exp_bytes = 0;
            recal     = 1'b1;
        end else begin
            chk({tag, ".st_run"}, bus.state_o, 3);
        end
    endtask

    initial begin
        logic        r;
        logic [7:0]  d;
        int unsigned cyc;

        bus.start = 1'b0; bus.stop = 1'b0; bus.clear_flags = 1'b0; bus.cal_done = 1'b0;
        bus.sample_valid = 1'b0; bus.sample_bit = 1'b0; bus.fifo_full = 1'b0;
        exp_din = '0; exp_ovf = 1'b0; exp_err = 1'b0; exp_bytes = 0;

        #12;
        chk_reset_vals("rst_held");
        rst_n = 1'b1;
        tick();
        chk_reset_vals("rst_idle");

        // Nominal flow
        start_cal("nom");
        wait_cal("nom", 50);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("start_in_run.st",      bus.state_o,     3);
        chk("start_in_run.restart", bus.cal_restart, 0);
        send_byte("nom_a5", 8'hA5, 1'b0, 0, 1'b0, r);
        send_byte("nom_3c", 8'h3C, 1'b0, 0, 1'b0, r);
        send_byte("nom_r3", 8'($urandom), 1'b0, 2, 1'b0, r);
        send_byte("nom_r4", 8'($urandom), 1'b0, 2, 1'b0, r);
        if (r) wait_cal("recal1", $urandom_range(40, 5));

        // Overflow, then clear, then set-wins-over-clear
        send_byte("ovf_ff",   8'hFF, 1'b1, 1, 1'b0, r);
        send_byte("ovf_next", 8'($urandom), 1'b0, 1, 1'b0, r);
        bus.clear_flags = 1'b1;
        tick();
        bus.clear_flags = 1'b0;
        exp_ovf = 1'b0;
        exp_err = 1'b0;
        chk_flags("clr");
        send_byte("setwins", 8'($urandom), 1'b1, 0, 1'b1, r);

        // Randomized traffic
        for (int unsigned n = 0; n < 12; n++) begin
            send_byte("rnd", 8'($urandom), ($urandom_range(3, 0) == 0), 2,
                      ($urandom_range(3, 0) == 0), r);
            if (r) wait_cal("rnd_recal", $urandom_range(TMO, 1));
        end

        // Stop mid-word with a same-cycle sample
        for (int unsigned k = 0; k < 4; k++) begin
            send_bit(1'($urandom_range(1, 0)), 1'b0, 1'b0, 1'b0);
            chk("stop5.wr", bus.fifo_wr_en, 0);
        end
        send_bit(1'b1, 1'b0, 1'b1, 1'b0);
        chk("stop5.st_drain", bus.state_o,      4);
        chk("stop5.busy",     bus.busy,         1);
        chk("stop5.pce",      bus.phase_cal_en, 0);
        chk("stop5.wr_drain", bus.fifo_wr_en,   0);
        tick();
        chk("stop5.st_idle", bus.state_o,    0);
        chk("stop5.busy_lo", bus.busy,       0);
        chk("stop5.wr_idle", bus.fifo_wr_en, 0);
        chk("stop5.din",     bus.fifo_din,   exp_din);
        for (int unsigned k = 0; k < 8; k++) begin
            send_bit(1'b1, 1'b0, 1'b0, 1'b0);
            chk("idle_ignored.wr", bus.fifo_wr_en, 0);
        end
        chk("idle_ignored.st", bus.state_o, 0);

        // Stop on the last bit: the pending write completes in DRAIN
        start_cal("s8");
        wait_cal("s8", 3);
        d = 8'($urandom);
        for (int unsigned k = 0; k < 7; k++) send_bit(d[7 - k], 1'b0, 1'b0, 1'b0);
        send_bit(d[0], 1'b0, 1'b1, 1'b0);
        exp_din = d;
        chk("stop8.st_drain", bus.state_o,    4);
        chk("stop8.wr",       bus.fifo_wr_en, 1);
        chk("stop8.din",      bus.fifo_din,   exp_din);
        tick();
        chk("stop8.st_idle",  bus.state_o,    0);
        chk("stop8.wr_lo",    bus.fifo_wr_en, 0);

        // Calibration timeout
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        cyc = 1;
        while (bus.state_o !== 3'd5 && cyc < TMO + 10) begin
            tick();
            cyc++;
        end
        exp_err = 1'b1;
        chk("tmo.cycle",   cyc,              TMO + 2);
        chk("tmo.st",      bus.state_o,      5);
        chk("tmo.pce",     bus.phase_cal_en, 0);
        chk("tmo.busy",    bus.busy,         1);
        chk("tmo.restart", bus.cal_restart,  0);
        chk_flags("tmo");
        bus.clear_flags = 1'b1;
        tick();
        bus.clear_flags = 1'b0;
        exp_err = 1'b0;
        exp_ovf = 1'b0;
        chk_flags("err_clr");
        chk("err_clr.st", bus.state_o, 5);
        start_cal("from_err");
        wait_cal("done_at_limit", TMO);

        // Asynchronous reset mid-word
        for (int unsigned k = 0; k < 3; k++) send_bit(1'b1, 1'b0, 1'b0, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        exp_din = '0; exp_ovf = 1'b0; exp_err = 1'b0; exp_bytes = 0;
        chk_reset_vals("async_rst");
        tick();
        rst_n = 1'b1;
        tick();
        chk_reset_vals("after_rst");
        start_cal("post_rst");
        wait_cal("post_rst", 3);
        send_byte("post_81", 8'h81, 1'b0, 0, 1'b0, r);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/spi_rx_sequencer.md
# spi_rx_sequencer

Top-level controller for the SPI receive path. Launches and supervises phase calibration of the calibration FSM and the data select stage. After calibration it packs recovered serial bits into bytes, writes them to the receive FIFO and forces periodic recalibration. Reports timeout, overflow and status. Sits between the data select stage (bit source) and the sync FIFO write port, all in the CLK_40 domain.

## Interface
Parameters:
- CAL_TIMEOUT, 1023: max CLK_40 cycles in CAL_WAIT before declaring calibration failure
- RECAL_BYTES, 4096: bytes written (or dropped) in RUN before an automatic recalibration
- FRAME_BITS, 8: bits per output word, MSB first

Ports (one clock; `reset` is asynchronous and active-low):
- CLK_40  input  1  system clock
- reset  input  1  asynchronous, active-low; all state and outputs clear while low
- start  input  1  level; launch calibration from IDLE or ERROR
- stop  input  1  level; leave RUN
- clear_flags  input  1  single-cycle pulse; clears sticky flags
- cal_done  input  1  high when phase_adjust is valid (calibration FSM in ADJUST)
- sample_valid  input  1  single-cycle pulse per recovered bit
- sample_bit  input  1  recovered bit, qualified by sample_valid
- fifo_full  input  1  FIFO full
- phase_cal_en  output  1  calibration enable to calibration FSM and data_select
- cal_restart  output  1  single-cycle pulse; synchronous restart of the calibration FSM and data_select
- fifo_wr_en  output  1  FIFO write strobe
- fifo_din  output  FRAME_BITS  assembled word
- busy  output  1  state != IDLE
- cal_error  output  1  sticky; calibration timeout
- overflow  output  1  sticky; word dropped on full
- state_o  output  3  current state encoding, for debug

## Operation
- States: IDLE=0, CAL_START=1, CAL_WAIT=2, RUN=3, DRAIN=4, ERROR=5.
- IDLE: if `start`, go to CAL_START.
- CAL_START (1 cycle):
  - assert cal_restart
  - clear the timeout counter, bit counter, shift register and byte counter
  - go to CAL_WAIT
- CAL_WAIT: count cycles.
  - If cal_done, go to RUN.
  - If the count equals CAL_TIMEOUT, set cal_error and go to ERROR.
  - cal_done wins if both occur in the same cycle.
- RUN, on sample_valid:
  - shift sample_bit into the LSB
  - increment the bit counter (width $clog2(FRAME_BITS))
- RUN, on the FRAME_BITS-th bit:
  - bit counter wraps to 0 and the byte counter increments
  - if !fifo_full, present the word on fifo_din and write it; otherwise drop the word and set overflow
- RUN, exits:
  - `stop` goes to DRAIN; it has priority over recalibration.
  - Otherwise, if the byte counter reached RECAL_BYTES, go to CAL_START.
  - A sample_valid in the same cycle as `stop` is still accepted.
- DRAIN (1 cycle): a pending write completes, a partial word is discarded, then go to IDLE.
- ERROR:
  - phase_cal_en is low
  - `start` goes to CAL_START; cal_error stays set until clear_flags
- Ignored inputs:
  - sample_valid outside RUN
  - `start` outside IDLE/ERROR
- clear_flags clears cal_error and overflow. If a set event occurs in the same cycle, the set wins.
- phase_cal_en is high exactly in CAL_START, CAL_WAIT and RUN.

## Timing
- All outputs are registered.
- Reset values:
  - state IDLE, state_o 0
  - phase_cal_en 0, cal_restart 0, fifo_wr_en 0, fifo_din 0
  - busy 0, cal_error 0, overflow 0
- `start` sampled in IDLE: phase_cal_en and cal_restart are high in cycle +1, busy is high in cycle +1.
- Write latency: fifo_wr_en is a 1-cycle pulse in the cycle after the sample_valid carrying the last bit. fifo_din holds the word until the next write.
- fifo_full is sampled in the same cycle as the last-bit sample_valid.
- cal_done to RUN: 1 cycle. The first sample_valid accepted is the one in the cycle after entering RUN.
- Back-to-back sample_valid on consecutive cycles must be supported with no loss.
- Reset asserted mid-operation: immediate return to reset values; a partial word is lost.

## Structure
- Shared package `spi_rx_pkg`:
  - `rx_seq_state_t` enum, logic [2:0], with the encodings above
  - default FRAME_BITS constant
- Sub-module `rx_word_assembler`: holds the shift register, bit counter and word-complete pulse, with a sync clear from CAL_START.
- The FSM, timeout counter, byte counter and flags stay in the top.

## Test plan
- Nominal: start, cal_done after 50 cycles, then 16 sample_valid of 0xA5, 0x3C → two writes, fifo_din 0xA5 then 0x3C, each 1 cycle after the 8th/16th bit; overflow 0.
- Timeout: CAL_TIMEOUT=15, start, no cal_done → cal_error=1, state_o=5, phase_cal_en=0 in cycle 17; start again → cal_restart pulse.
- Overflow: fifo_full=1 at the 8th bit of 0xFF → no fifo_wr_en, overflow=1. Next word with fifo_full=0 is written. clear_flags → overflow=0.
- Recalibration: RECAL_BYTES=2, two words received → CAL_START, cal_restart pulse, phase_cal_en stays high, byte counter 0.
- Stop mid-word: stop after 5 bits, with sample_valid in the same cycle → DRAIN then IDLE, no write, busy=0.
- Async reset: reset low during RUN with 3 bits shifted → all outputs at reset values immediately. After release, start/cal_done and 8 bits of 0x81 → fifo_din 0x81.
